// File: rtl/tri_bus_ctrl.sv
// tri_bus_ctrl: half-duplex bus controller that drives tri_buffer a/en, paces writes with turnaround, and captures reads after settle.
module tri_bus_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DRIVE_CYC  = 2,
  parameter int TURN_CYC   = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;
  state_t           state_q;
  logic [7:0]       cnt_q;
  logic             bus_oe_q, rx_valid_q;
  logic [WIDTH-1:0] bus_out_q, rx_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bus_oe_q   <= 1'b0;
      bus_out_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE:
          if (tx_valid) begin
            state_q   <= DRIVE;
            cnt_q     <= 8'(DRIVE_CYC - 1);
            bus_oe_q  <= 1'b1;
            bus_out_q <= tx_data;
          end else if (rx_req) begin
            state_q <= SAMPLE;
            cnt_q   <= 8'(SETTLE_CYC - 1);
          end
        DRIVE:
          if (cnt_q == 8'd0) begin
            state_q   <= (TURN_CYC == 0) ? IDLE : TURN;
            cnt_q     <= 8'((TURN_CYC == 0) ? 0 : TURN_CYC - 1);
            bus_oe_q  <= 1'b0;
            bus_out_q <= '0;
          end else cnt_q <= cnt_q - 8'd1;
        TURN:
          if (cnt_q == 8'd0) state_q <= IDLE;
          else cnt_q <= cnt_q - 8'd1;
        SAMPLE:
          if (cnt_q == 8'd0) begin
            state_q    <= IDLE;
            rx_data_q  <= bus_in;
            rx_valid_q <= 1'b1;
          end else cnt_q <= cnt_q - 8'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign tx_ready = (state_q == IDLE) && !rst;
  assign busy     = state_q != IDLE;
  assign bus_oe   = bus_oe_q;
  assign bus_out  = bus_out_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
endmodule
